// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, controller numbers,
// parser-state and event enums, the event bundle and its decoder.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF         = 4'h8;
    localparam logic [3:0] NOTE_ON          = 4'h9;
    localparam logic [3:0] CTRL             = 4'hB;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [1:0] {
        PS_IDLE  = 2'd0,
        PS_DATA1 = 2'd1,
        PS_DATA2 = 2'd2,
        PS_SKIP  = 2'd3
    } parse_state_e;

    typedef enum logic [1:0] {
        EV_NONE     = 2'd0,
        EV_NOTE_ON  = 2'd1,
        EV_NOTE_OFF = 2'd2,
        EV_ALL_OFF  = 2'd3
    } evt_type_e;

    typedef struct packed {
        evt_type_e  kind;
        logic [6:0] note;
        logic [6:0] vel;
    } midi_evt_t;

    // Turns a completed two-data-byte message into an event.
    // Note-on with zero velocity is a note-off by MIDI convention.
    function automatic midi_evt_t decode_evt(
        input logic [3:0] hi,
        input logic [6:0] d1,
        input logic [6:0] d2
    );
        midi_evt_t e;
        e.kind = EV_NONE;
        e.note = d1;
        e.vel  = d2;
        if (hi == NOTE_ON && d2 != 7'd0) begin
            e.kind = EV_NOTE_ON;
        end else if (hi == NOTE_ON || hi == NOTE_OFF) begin
            e.kind = EV_NOTE_OFF;
            e.vel  = 7'd0;
        end else if (hi == CTRL && d1 == CC_ALL_NOTES_OFF) begin
            e.kind = EV_ALL_OFF;
        end
        return e;
    endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// Byte-to-event parser with running status and channel filter.
// Ports: clk, reset_n, i_data/i_valid (byte strobe),
//        o_evt (registered event, one cycle), o_state (debug).
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output midi_evt_t  o_evt,
    output logic [1:0] o_state
);

    parse_state_e r_state;
    parse_state_e w_state_nxt;
    logic [7:0]   r_status;
    logic [7:0]   w_status_nxt;
    logic [6:0]   r_d1;
    logic [6:0]   w_d1_nxt;
    midi_evt_t    r_evt;
    midi_evt_t    w_evt_nxt;

    logic w_is_rt;
    logic w_is_sys;
    logic w_is_chst;
    logic w_is_data;
    logic w_voice;
    logic w_chan_ok;

    // Byte classes are mutually exclusive and cover all 256 values.
    assign w_is_rt   = (i_data[7:3] == 5'b11111);
    assign w_is_sys  = (i_data[7:3] == 5'b11110);
    assign w_is_chst = i_data[7] && (i_data[7:4] != 4'hF);
    assign w_is_data = !i_data[7];

    assign w_voice   = (i_data[7:4] == NOTE_OFF) ||
                       (i_data[7:4] == NOTE_ON)  ||
                       (i_data[7:4] == CTRL);
    assign w_chan_ok = OMNI || (i_data[3:0] == CHANNEL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= PS_IDLE;
            r_status <= 8'h00;
            r_d1     <= 7'd0;
            r_evt    <= '{kind: EV_NONE, note: 7'd0, vel: 7'd0};
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            r_d1     <= w_d1_nxt;
            r_evt    <= w_evt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_d1_nxt     = r_d1;
        w_evt_nxt    = '{kind: EV_NONE, note: 7'd0, vel: 7'd0};
        if (i_valid) begin
            unique case (1'b1)
                w_is_rt: begin
                end
                w_is_sys: begin
                    w_status_nxt = 8'h00;
                    w_state_nxt  = PS_SKIP;
                end
                // Rejected statuses are still kept so their
                // data bytes are swallowed in SKIP.
                w_is_chst: begin
                    w_status_nxt = i_data;
                    w_state_nxt  = (w_voice && w_chan_ok)
                                 ? PS_DATA1 : PS_SKIP;
                end
                w_is_data: begin
                    unique case (r_state)
                        PS_DATA1: begin
                            w_d1_nxt    = i_data[6:0];
                            w_state_nxt = PS_DATA2;
                        end
                        PS_DATA2: begin
                            w_evt_nxt   = decode_evt(r_status[7:4],
                                                     r_d1,
                                                     i_data[6:0]);
                            w_state_nxt = PS_DATA1;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign o_evt   = r_evt;
    assign o_state = r_state;

endmodule

// File: rtl/midi_voice_alloc.sv
// MIDI note handler: parses channel-voice messages and allocates
// up to NVOICES voices (match -> free -> round-robin steal).
// Ports: clk, reset_n, rx_data/rx_ready (UART byte strobe);
//        voice_gate/note/vel/trig (packed per voice), steal,
//        parse_state (debug).
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int         NVOICES = 8,
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    output logic [NVOICES-1:0]     voice_gate,
    output logic [7*NVOICES-1:0]   voice_note,
    output logic [7*NVOICES-1:0]   voice_vel,
    output logic [NVOICES-1:0]     voice_trig,
    output logic                   steal,
    output logic [1:0]             parse_state
);

    localparam int PW = $clog2(NVOICES);
    localparam logic [PW-1:0] LAST = PW'(NVOICES - 1);

    midi_evt_t w_evt;

    logic [NVOICES-1:0] r_gate;
    logic [6:0]         r_note [NVOICES];
    logic [6:0]         r_vel  [NVOICES];
    logic [NVOICES-1:0] r_trig;
    logic               r_steal;
    logic [PW-1:0]      r_steal_ptr;

    logic               w_match_hit;
    logic [PW-1:0]      w_match_idx;
    logic               w_free_hit;
    logic [PW-1:0]      w_free_idx;
    logic [PW-1:0]      w_tgt;
    logic               w_do_steal;
    logic [NVOICES-1:0] w_off_mask;

    midi_msg_parser #(
        .CHANNEL (CHANNEL),
        .OMNI    (OMNI)
    ) u_parser (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (rx_data),
        .i_valid (rx_ready),
        .o_evt   (w_evt),
        .o_state (parse_state)
    );

    // Scan from the top down so the lowest index is left standing.
    always_comb begin
        w_match_hit = 1'b0;
        w_match_idx = '0;
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        w_off_mask  = '0;
        for (int i = NVOICES - 1; i >= 0; i--) begin
            if (r_gate[i] && r_note[i] == w_evt.note) begin
                w_match_hit   = 1'b1;
                w_match_idx   = PW'(i);
                w_off_mask[i] = 1'b1;
            end
            if (!r_gate[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = PW'(i);
            end
        end
    end

    always_comb begin
        w_do_steal = 1'b0;
        w_tgt      = r_steal_ptr;
        if (w_match_hit) begin
            w_tgt = w_match_idx;
        end else if (w_free_hit) begin
            w_tgt = w_free_idx;
        end else begin
            w_do_steal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gate      <= '0;
            r_trig      <= '0;
            r_steal     <= 1'b0;
            r_steal_ptr <= '0;
            for (int i = 0; i < NVOICES; i++) begin
                r_note[i] <= 7'd0;
                r_vel[i]  <= 7'd0;
            end
        end else begin
            r_trig  <= '0;
            r_steal <= 1'b0;
            unique case (w_evt.kind)
                EV_NOTE_ON: begin
                    r_gate[w_tgt] <= 1'b1;
                    r_note[w_tgt] <= w_evt.note;
                    r_vel[w_tgt]  <= w_evt.vel;
                    r_trig[w_tgt] <= 1'b1;
                    if (w_do_steal) begin
                        r_steal     <= 1'b1;
                        r_steal_ptr <= (r_steal_ptr == LAST)
                                     ? '0 : r_steal_ptr + 1'b1;
                    end
                end
                // note/vel stay put for the release stage.
                EV_NOTE_OFF: begin
                    r_gate <= r_gate & ~w_off_mask;
                end
                EV_ALL_OFF: begin
                    r_gate <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < NVOICES; g++) begin : g_pack
        assign voice_note[7*g +: 7] = r_note[g];
        assign voice_vel[7*g +: 7]  = r_vel[g];
    end

    assign voice_gate = r_gate;
    assign voice_trig = r_trig;
    assign steal      = r_steal;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Self-checking bench for midi_voice_alloc: directed scenarios
// plus random byte streams against a behavioural voice model.
module tb_midi_voice_alloc;

    localparam int NV = 8;
    localparam int CH = 0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready = 1'b0;
    logic [NV-1:0] voice_gate;
    logic [7*NV-1:0] voice_note;
    logic [7*NV-1:0] voice_vel;
    logic [NV-1:0] voice_trig;
    logic          steal;
    logic [1:0]    parse_state;

    midi_voice_alloc #(
        .NVOICES (NV),
        .CHANNEL (4'(CH)),
        .OMNI    (1'b0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .voice_gate  (voice_gate),
        .voice_note  (voice_note),
        .voice_vel   (voice_vel),
        .voice_trig  (voice_trig),
        .steal       (steal),
        .parse_state (parse_state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: voice bank
    bit       m_gate [NV];
    int       m_note [NV];
    int       m_vel  [NV];
    int       m_ptr;
    bit [NV-1:0] m_trig;
    bit       m_steal;
    // Model: parser. mode 0 = no status, 1 = accepted, 2 = skip
    int m_mode;
    int m_status;
    int m_nd;
    int m_d1;

    logic [NV-1:0] last_trig;
    logic          last_steal;

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 3;
        return (m_nd == 0) ? 1 : 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0;
            m_note[i] = 0;
            m_vel[i]  = 0;
        end
        m_ptr = 0;
        m_trig = '0;
        m_steal = 0;
        m_mode = 0;
        m_status = 0;
        m_nd = 0;
        m_d1 = 0;
    endtask

    // ev: 0 none, 1 on, 2 off, 3 all off
    task automatic model_parse(input int b, output int ev,
                               output int n, output int v);
        int hi;
        ev = 0;
        n = 0;
        v = 0;
        hi = b / 16;
        if (b >= 'hF8) begin
        end else if (b >= 'hF0) begin
            m_mode = 2;
            m_nd = 0;
        end else if (b >= 'h80) begin
            m_nd = 0;
            m_status = b;
            if ((hi == 8 || hi == 9 || hi == 11) && (b % 16) == CH)
                m_mode = 1;
            else
                m_mode = 2;
        end else if (m_mode == 1) begin
            if (m_nd == 0) begin
                m_d1 = b;
                m_nd = 1;
            end else begin
                m_nd = 0;
                n = m_d1;
                v = b;
                hi = m_status / 16;
                if (hi == 9 && b != 0) ev = 1;
                else if (hi == 9 || hi == 8) ev = 2;
                else if (m_d1 == 123) ev = 3;
            end
        end
    endtask

    task automatic model_apply(input int ev, input int n, input int v);
        int t;
        t = -1;
        if (ev == 1) begin
            for (int i = 0; i < NV; i++)
                if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
            for (int i = 0; i < NV; i++)
                if (t < 0 && !m_gate[i]) t = i;
            if (t < 0) begin
                t = m_ptr;
                m_ptr = (m_ptr + 1) % NV;
                m_steal = 1;
            end
            m_gate[t] = 1;
            m_note[t] = n;
            m_vel[t] = v;
            m_trig[t] = 1;
        end else if (ev == 2) begin
            for (int i = 0; i < NV; i++)
                if (m_note[i] == n) m_gate[i] = 0;
        end else if (ev == 3) begin
            for (int i = 0; i < NV; i++) m_gate[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NV-1:0]   eg;
            logic [7*NV-1:0] en;
            logic [7*NV-1:0] ev;
            for (int i = 0; i < NV; i++) begin
                eg[i] = m_gate[i];
                en[7*i +: 7] = 7'(m_note[i]);
                ev[7*i +: 7] = 7'(m_vel[i]);
            end
            check("gate", 64'(voice_gate), 64'(eg));
            check("note", 64'(voice_note), 64'(en));
            check("vel", 64'(voice_vel), 64'(ev));
            check("trig", 64'(voice_trig), 64'(m_trig));
            check("steal", 64'(steal), 64'(m_steal));
            check("pstate", 64'(parse_state), 64'(exp_state()));
        end
    end

    // Byte accepted at edge E1, event registered at E1,
    // voices update at E2, trig/steal drop at E3.
    task automatic send(input int b);
        int ev, n, v;
        @(posedge clk);
        #1;
        rx_data = 8'(b);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        model_parse(b, ev, n, v);
        @(posedge clk);
        #1;
        model_apply(ev, n, v);
        last_trig = voice_trig;
        last_steal = steal;
        @(posedge clk);
        #1;
        m_trig = '0;
        m_steal = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic int rnd_byte();
        int r, ch;
        r = $urandom_range(0, 99);
        ch = ($urandom_range(0, 2) != 0) ? CH : $urandom_range(0, 3);
        if (r < 10) return 'h90 + ch;
        if (r < 16) return 'h80 + ch;
        if (r < 20) return 'hB0 + ch;
        if (r < 23) return 16 * $urandom_range(10, 14) + ch;
        if (r < 26) return $urandom_range('hF0, 'hF7);
        if (r < 32) return $urandom_range('hF8, 'hFF);
        r = $urandom_range(0, 99);
        if (r < 45) return 60 + $urandom_range(0, 9);
        if (r < 60) return 0;
        if (r < 70) return 123;
        return $urandom_range(0, 127);
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en = 1'b1;
        check("rst_gate", 64'(voice_gate), 64'h0);

        // Single note-on
        send('h90); send('h3C); send('h64);
        check("s1_trig", 64'(last_trig), 64'h01);
        check("s1_gate", 64'(voice_gate), 64'h01);
        check("s1_note", 64'(voice_note[6:0]), 64'd60);
        check("s1_vel", 64'(voice_vel[6:0]), 64'd100);

        // Running status and note-off via zero velocity
        send('h3E); send('h50);
        send('h3C); send('h00);
        check("s2_gate", 64'(voice_gate), 64'h02);
        check("s2_n1", 64'(voice_note[13:7]), 64'd62);
        check("s2_n0", 64'(voice_note[6:0]), 64'd60);

        // Steal
        do_reset();
        send('h90);
        for (int i = 0; i < 9; i++) begin
            send(70 + i); send(40 + i);
        end
        check("s3_steal", 64'(last_steal), 64'h1);
        check("s3_trig", 64'(last_trig), 64'h01);
        check("s3_n0", 64'(voice_note[6:0]), 64'd78);
        send(90); send(1);
        check("s3_trig2", 64'(last_trig), 64'h02);
        check("s3_steal2", 64'(last_steal), 64'h1);

        // Real-time bytes interleaved
        do_reset();
        send('h90); send('hF8); send('h3C);
        send('hFE); send('h64);
        check("s4_gate", 64'(voice_gate), 64'h01);
        check("s4_note", 64'(voice_note[6:0]), 64'd60);
        check("s4_vel", 64'(voice_vel[6:0]), 64'd100);

        // Foreign channel, then all-notes-off
        do_reset();
        send('h92); send('h40); send('h40);
        check("s5_gate0", 64'(voice_gate), 64'h0);
        send('h90);
        for (int i = 0; i < 4; i++) begin
            send(50 + i); send(30);
        end
        check("s5_gate4", 64'(voice_gate), 64'h0F);
        send('hB0); send('h7B); send('h00);
        check("s5_alloff", 64'(voice_gate), 64'h0);

        // Reset mid-message
        do_reset();
        send('h90); send('h3C);
        do_reset();
        check("s6_state", 64'(parse_state), 64'd0);
        send('h64);
        check("s6_gate", 64'(voice_gate), 64'h0);
        check("s6_state2", 64'(parse_state), 64'd0);

        // Random streams
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            send(rnd_byte());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
